rmgmt_mem_arbiter: RTL and testbench

Pipeline-side responder for RISC-MGMT memory requests. Arbitrates between the core's execute-stage data port and a RISC-MGMT extension's memory request (req_mem/mem_ren/mem_wen/mem_addr/mem_store) onto a single generic data-bus master. Returns mem_load/mem_busy to RISC-MGMT and rdata/busy to the core. It sits between the execute stage and the dcache/bus bridge. Requests are registered, a transfer timeout is provided, and misaligned RISC-MGMT accesses are flagged.

---
 rtl/rmgmt_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rmgmt_mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rmgmt_mem_arbiter.sv
// Arbitrates RISC-MGMT and core data requests onto one bus master with
// latched transfer state, per-owner load data, a busy timeout and misalignment flagging.
module rmgmt_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        core_ren,
   input  logic        core_wen,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_byte_en,
   output logic [31:0] core_rdata,
   output logic        core_busy,
   input  logic        req_mem,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_store,
   output logic [31:0] mem_load,
   output logic        mem_busy,
   output logic        mem_misaligned,
   output logic        bus_ren,
   output logic        bus_wen,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byte_en,
   input  logic [31:0] bus_rdata,
   input  logic        bus_busy,
   output logic        bus_timeout
);

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_XFER   = 2'd1;
   localparam logic [1:0]  ST_DONE   = 2'd2;
   localparam logic [1:0]  OWN_NONE  = 2'd0;
   localparam logic [1:0]  OWN_CORE  = 2'd1;
   localparam logic [1:0]  OWN_RMGMT = 2'd2;
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
   localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);

   logic [1:0]  state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ben_q, ben_d;
   logic        ren_q, ren_d;
   logic        wen_q, wen_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] core_rdata_q, core_rdata_d;
   logic [31:0] mem_load_q, mem_load_d;

   logic live_mem_s;
   logic core_req_s;
   logic misaligned_s;
   logic timeout_s;

   assign live_mem_s   = req_mem & (mem_ren | mem_wen);
   assign core_req_s   = core_ren | core_wen;
   assign misaligned_s = (state_q == ST_IDLE) & live_mem_s & (mem_addr[1:0] != 2'b00);
   assign timeout_s    = TMO_EN & (state_q == ST_XFER) & bus_busy & (cnt_q == TMO_LIMIT);

   // Next-state: arbitration in IDLE, completion/timeout in XFER.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ben_d        = ben_q;
      ren_d        = ren_q;
      wen_d        = wen_q;
      cnt_d        = cnt_q;
      core_rdata_d = core_rdata_q;
      mem_load_d   = mem_load_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 32'd0;
            if (live_mem_s) begin
               owner_d = OWN_RMGMT;
               if (misaligned_s) begin
                  mem_load_d = 32'd0;
                  state_d    = ST_DONE;
               end else begin
                  addr_d  = mem_addr;
                  wdata_d = mem_store;
                  ben_d   = 4'hF;
                  wen_d   = mem_wen;
                  ren_d   = mem_ren & ~mem_wen;
                  state_d = ST_XFER;
               end
            end else if (core_req_s) begin
               owner_d = OWN_CORE;
               addr_d  = core_addr;
               wdata_d = core_wdata;
               ben_d   = core_byte_en;
               wen_d   = core_wen;
               ren_d   = core_ren & ~core_wen;
               state_d = ST_XFER;
            end else begin
               owner_d = OWN_NONE;
            end
         end
         ST_XFER: begin
            if (timeout_s) begin
               if (owner_q == OWN_RMGMT) begin
                  mem_load_d = 32'd0;
               end else begin
                  core_rdata_d = 32'd0;
               end
               state_d = ST_DONE;
            end else if (!bus_busy) begin
               if (ren_q && (owner_q == OWN_RMGMT)) begin
                  mem_load_d = bus_rdata;
               end else if (ren_q) begin
                  core_rdata_d = bus_rdata;
               end else begin
                  mem_load_d = mem_load_q;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_NONE;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         ben_q        <= 4'd0;
         ren_q        <= 1'b0;
         wen_q        <= 1'b0;
         cnt_q        <= 32'd0;
         core_rdata_q <= 32'd0;
         mem_load_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ben_q        <= ben_d;
         ren_q        <= ren_d;
         wen_q        <= wen_d;
         cnt_q        <= cnt_d;
         core_rdata_q <= core_rdata_d;
         mem_load_q   <= mem_load_d;
      end
   end

   // The timeout cycle already drops the strobe so the bus sees the abort immediately.
   assign bus_ren        = (state_q == ST_XFER) & ren_q & ~timeout_s;
   assign bus_wen        = (state_q == ST_XFER) & wen_q & ~timeout_s;
   assign bus_addr       = addr_q;
   assign bus_wdata      = wdata_q;
   assign bus_byte_en    = ben_q;
   assign bus_timeout    = timeout_s;
   assign mem_misaligned = misaligned_s;
   assign core_rdata     = core_rdata_q;
   assign mem_load       = mem_load_q;
   assign core_busy      = core_req_s & ~((state_q == ST_DONE) & (owner_q == OWN_CORE));
   assign mem_busy       = live_mem_s & ~((state_q == ST_DONE) & (owner_q == OWN_RMGMT));

endmodule

// File: tb/tb_rmgmt_mem_arbiter.sv
// Cycle-by-cycle directed vectors for rmgmt_mem_arbiter with TIMEOUT_CYCLES=4.
module tb_rmgmt_mem_arbiter;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;
   localparam logic [31:0] Z = 32'h0;

   typedef struct {
      logic rst; logic c_ren; logic c_wen; logic [31:0] c_addr; logic [31:0] c_wdata; logic [3:0] c_be;
      logic req; logic m_ren; logic m_wen; logic [31:0] m_addr; logic [31:0] m_store;
      logic [31:0] b_rdata; logic b_busy;
      logic e_bren; logic e_bwen; logic [31:0] e_baddr; logic [31:0] e_bwdata; logic [3:0] e_bbe;
      logic e_cbusy; logic e_mbusy; logic [31:0] e_crdata; logic [31:0] e_mload; logic e_mis; logic e_tmo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_ren, core_wen, req_mem, mem_ren, mem_wen, bus_busy;
   logic [31:0] core_addr, core_wdata, mem_addr, mem_store, bus_rdata;
   logic [3:0]  core_byte_en;
   logic [31:0] core_rdata, mem_load, bus_addr, bus_wdata;
   logic        core_busy, mem_busy, mem_misaligned, bus_ren, bus_wen, bus_timeout;
   logic [3:0]  bus_byte_en;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vq[$];

   rmgmt_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(clk), .RST(rst),
      .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_byte_en(core_byte_en), .core_rdata(core_rdata), .core_busy(core_busy),
      .req_mem(req_mem), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_store(mem_store), .mem_load(mem_load), .mem_busy(mem_busy), .mem_misaligned(mem_misaligned),
      .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rst_i, c_ren, c_wen, input logic [31:0] c_addr, c_wdata, input logic [3:0] c_be,
      input logic req, m_ren, m_wen, input logic [31:0] m_addr, m_store, b_rdata, input logic b_busy,
      input logic e_bren, e_bwen, input logic [31:0] e_baddr, e_bwdata, input logic [3:0] e_bbe,
      input logic e_cbusy, e_mbusy, input logic [31:0] e_crdata, e_mload, input logic e_mis, e_tmo);
      vec_t v;
      v.rst = rst_i; v.c_ren = c_ren; v.c_wen = c_wen; v.c_addr = c_addr; v.c_wdata = c_wdata; v.c_be = c_be;
      v.req = req; v.m_ren = m_ren; v.m_wen = m_wen; v.m_addr = m_addr; v.m_store = m_store;
      v.b_rdata = b_rdata; v.b_busy = b_busy;
      v.e_bren = e_bren; v.e_bwen = e_bwen; v.e_baddr = e_baddr; v.e_bwdata = e_bwdata; v.e_bbe = e_bbe;
      v.e_cbusy = e_cbusy; v.e_mbusy = e_mbusy; v.e_crdata = e_crdata; v.e_mload = e_mload;
      v.e_mis = e_mis; v.e_tmo = e_tmo;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs after the edge, compare outputs on the falling edge.
   task automatic step(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      rst = v.rst; core_ren = v.c_ren; core_wen = v.c_wen; core_addr = v.c_addr;
      core_wdata = v.c_wdata; core_byte_en = v.c_be; req_mem = v.req; mem_ren = v.m_ren;
      mem_wen = v.m_wen; mem_addr = v.m_addr; mem_store = v.m_store;
      bus_rdata = v.b_rdata; bus_busy = v.b_busy;
      @(negedge clk);
      chk("bus_ren", idx, 32'(bus_ren), 32'(v.e_bren));
      chk("bus_wen", idx, 32'(bus_wen), 32'(v.e_bwen));
      if (v.e_bren || v.e_bwen) begin
         chk("bus_addr", idx, bus_addr, v.e_baddr);
         chk("bus_wdata", idx, bus_wdata, v.e_bwdata);
         chk("bus_byte_en", idx, 32'(bus_byte_en), 32'(v.e_bbe));
      end
      chk("core_busy", idx, 32'(core_busy), 32'(v.e_cbusy));
      chk("mem_busy", idx, 32'(mem_busy), 32'(v.e_mbusy));
      chk("core_rdata", idx, core_rdata, v.e_crdata);
      chk("mem_load", idx, mem_load, v.e_mload);
      chk("mem_misaligned", idx, 32'(mem_misaligned), 32'(v.e_mis));
      chk("bus_timeout", idx, 32'(bus_timeout), 32'(v.e_tmo));
   endtask

   initial begin
      //          rst ren wen addr       wdata          be     req mr mw maddr      mstore      brdata         bb   bren bwen baddr      bwdata         bbe    cb mb crdata         mload          mis tmo
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      // core read, zero-wait
      vq.push_back(mk(N, Y, N, 32'h100,    Z,             4'hF,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  Y, N, Z,             Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h100,    Z,             4'hF,  N, N, N, Z,          Z,          32'hDEADBEEF,  N,   Y, N, 32'h100,    Z,             4'hF,  Y, N, Z,             Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h100,    Z,             4'hF,  N, N, N, Z,          Z,          32'hDEADBEEF,  N,   N, N, Z,          Z,             4'h0,  N, N, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hDEADBEEF,  Z,             N, N));
      // simultaneous RISC-MGMT write and core read
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  Y, N, Y, 32'h200,    32'h1234,   Z,             N,   N, N, Z,          Z,             4'h0,  Y, Y, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  Y, N, Y, 32'h200,    32'h1234,   Z,             N,   N, Y, 32'h200,    32'h1234,      4'hF,  Y, Y, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  Y, N, Y, 32'h200,    32'h1234,   Z,             N,   N, N, Z,          Z,             4'h0,  Y, N, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  Y, N, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  N, N, N, Z,          Z,          32'hCAFEF00D,  N,   Y, N, 32'h104,    Z,             4'h3,  Y, N, 32'hDEADBEEF,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h104,    Z,             4'h3,  N, N, N, Z,          Z,          32'hCAFEF00D,  N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      // RISC-MGMT aligned read
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, N, 32'h208,    Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, Y, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, N, 32'h208,    Z,          32'h13579BDF,  N,   Y, N, 32'h208,    Z,             4'hF,  N, Y, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, N, 32'h208,    Z,          32'h13579BDF,  N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  32'h13579BDF,  N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  32'h13579BDF,  N, N));
      // misaligned RISC-MGMT read
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, N, 32'h203,    Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, Y, 32'hCAFEF00D,  32'h13579BDF,  Y, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, N, 32'h203,    Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      // mem_ren without req_mem is not a request
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, Y, N, 32'h300,    Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, 32'hCAFEF00D,  Z,             N, N));
      // core read timing out after 4 busy cycles
      vq.push_back(mk(N, Y, N, 32'h400,    Z,             4'hF,  N, N, N, Z,          Z,          Z,             Y,   N, N, Z,          Z,             4'h0,  Y, N, 32'hCAFEF00D,  Z,             N, N));
      for (int k = 0; k < 4; k++)
         vq.push_back(mk(N, Y, N, 32'h400, Z,             4'hF,  N, N, N, Z,          Z,          Z,             Y,   Y, N, 32'h400,    Z,             4'hF,  Y, N, 32'hCAFEF00D,  Z,             N, N));
      vq.push_back(mk(N, Y, N, 32'h400,    Z,             4'hF,  N, N, N, Z,          Z,          Z,             Y,   N, N, Z,          Z,             4'h0,  Y, N, 32'hCAFEF00D,  Z,             N, Y));
      vq.push_back(mk(N, Y, N, 32'h400,    Z,             4'hF,  N, N, N, Z,          Z,          Z,             Y,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      // core write, 3 busy cycles, request fields change mid-transfer
      vq.push_back(mk(N, N, Y, 32'h500,    32'hA5A5A5A5,  4'hC,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  Y, N, Z,             Z,             N, N));
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(N, N, Y, 32'h600, 32'h5A5A5A5A,  4'hC,  N, N, N, Z,          Z,          Z,             Y,   N, Y, 32'h500,    32'hA5A5A5A5,  4'hC,  Y, N, Z,             Z,             N, N));
      vq.push_back(mk(N, N, Y, 32'h600,    32'h5A5A5A5A,  4'hC,  N, N, N, Z,          Z,          32'hFFFFFFFF,  N,   N, Y, 32'h500,    32'hA5A5A5A5,  4'hC,  Y, N, Z,             Z,             N, N));
      vq.push_back(mk(N, N, Y, 32'h600,    32'h5A5A5A5A,  4'hC,  N, N, N, Z,          Z,          32'hFFFFFFFF,  N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      // RISC-MGMT ren+wen behaves as a write
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, Y, 32'h700,    32'h77,     Z,             N,   N, N, Z,          Z,             4'h0,  N, Y, Z,             Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, Y, 32'h700,    32'h77,     32'h11111111,  N,   N, Y, 32'h700,    32'h77,        4'hF,  N, Y, Z,             Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  Y, Y, Y, 32'h700,    32'h77,     32'h11111111,  N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));
      vq.push_back(mk(N, N, N, Z,          Z,             4'h0,  N, N, N, Z,          Z,          Z,             N,   N, N, Z,          Z,             4'h0,  N, N, Z,             Z,             N, N));

      rst = 1'b1; core_ren = 1'b0; core_wen = 1'b0; core_addr = Z; core_wdata = Z; core_byte_en = 4'h0;
      req_mem = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = Z; mem_store = Z;
      bus_rdata = Z; bus_busy = 1'b0;
      repeat (3) @(posedge clk);

      foreach (vq[i]) step(vq[i], i);

      // Hand sequence: load nonzero core_rdata, then reset in the middle of a busy transfer.
      step(mk(N, Y, N, 32'h800, Z, 4'hF, N, N, N, Z, Z, Z,            N, N, N, Z,       Z, 4'h0, Y, N, Z,            Z, N, N), 100);
      step(mk(N, Y, N, 32'h800, Z, 4'hF, N, N, N, Z, Z, 32'hABCD0123, N, Y, N, 32'h800, Z, 4'hF, Y, N, Z,            Z, N, N), 101);
      step(mk(N, Y, N, 32'h800, Z, 4'hF, N, N, N, Z, Z, 32'hABCD0123, N, N, N, Z,       Z, 4'h0, N, N, 32'hABCD0123, Z, N, N), 102);
      step(mk(N, N, N, Z,       Z, 4'h0, N, N, N, Z, Z, Z,            N, N, N, Z,       Z, 4'h0, N, N, 32'hABCD0123, Z, N, N), 103);
      step(mk(N, Y, N, 32'h900, Z, 4'hF, N, N, N, Z, Z, Z,            Y, N, N, Z,       Z, 4'h0, Y, N, 32'hABCD0123, Z, N, N), 104);
      step(mk(N, Y, N, 32'h900, Z, 4'hF, N, N, N, Z, Z, Z,            Y, Y, N, 32'h900, Z, 4'hF, Y, N, 32'hABCD0123, Z, N, N), 105);
      step(mk(Y, Y, N, 32'h900, Z, 4'hF, N, N, N, Z, Z, Z,            Y, Y, N, 32'h900, Z, 4'hF, Y, N, 32'hABCD0123, Z, N, N), 106);
      step(mk(N, N, N, Z,       Z, 4'h0, N, N, N, Z, Z, Z,            Y, N, N, Z,       Z, 4'h0, N, N, Z,            Z, N, N), 107);
      step(mk(N, N, N, Z,       Z, 4'h0, N, N, N, Z, Z, Z,            Y, N, N, Z,       Z, 4'h0, N, N, Z,            Z, N, N), 108);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
